// File: rtl/alu_op_sequencer_if.sv
// Result stream bundle of the ALU opcode sequencer.
// Master drives one captured ALU result per beat; slave accepts with res_ready.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
);
  logic             res_valid;
  logic             res_ready;
  logic [SEL_W-1:0] res_op;
  logic [WIDTH-1:0] res_data;
  logic             res_cout;
  logic             res_last;

  modport master (
    output res_valid, res_op, res_data, res_cout, res_last,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_op, res_data, res_cout, res_last,
    output res_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU opcode sequencer: latches operands, sweeps every opcode,
// buffers each {cout, out} and streams the results over res.
module alu_op_sequencer #(
  parameter int WIDTH   = 8,
  parameter int SEL_W   = 3,
  parameter int NUM_OPS = 8,
  parameter int SETTLE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_cin,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [SEL_W-1:0] alu_s,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  output logic             done,
  alu_op_sequencer_if.master res
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_OPS - 1);
  localparam logic [3:0]       SETL = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STREAM
  } state_t;

  state_t state, state_n;

  logic [3:0]       cnt;
  logic [SEL_W-1:0] rd_ptr;
  logic             valid_q;
  logic [WIDTH:0]   res_buf [2**SEL_W];

  logic accept, settled, step, fire, last_fire;

  assign accept    = (state == IDLE) && start;
  assign settled   = (cnt == SETL);
  assign step      = (state == RUN) && settled;
  assign fire      = (state == STREAM) && valid_q && res.res_ready;
  assign last_fire = fire && (rd_ptr == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (settled && alu_s == LAST) state_n = STREAM;
      STREAM:  if (last_fire) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_cin <= 1'b0;
      alu_s   <= '0;
      cnt     <= '0;
      rd_ptr  <= '0;
      valid_q <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= last_fire;
      if (accept) begin
        alu_a   <= cmd_a;
        alu_b   <= cmd_b;
        alu_cin <= cmd_cin;
        alu_s   <= '0;
        cnt     <= '0;
      end
      if (state == RUN) begin
        if (!settled) begin
          cnt <= cnt + 4'd1;
        end else begin
          cnt <= '0;
          if (alu_s == LAST) begin
            rd_ptr  <= '0;
            valid_q <= 1'b1;
          end else begin
            alu_s <= alu_s + SEL_W'(1);
          end
        end
      end
      if (fire) begin
        if (last_fire) begin
          rd_ptr  <= '0;
          valid_q <= 1'b0;
        end else begin
          rd_ptr <= rd_ptr + SEL_W'(1);
        end
      end
    end
  end

  // Buffer is never cleared; outputs are gated by valid instead.
  always_ff @(posedge clk) begin
    if (step) res_buf[alu_s] <= {alu_cout, alu_out};
  end

  assign busy          = (state != IDLE);
  assign res.res_valid = valid_q;
  assign res.res_op    = valid_q ? rd_ptr : '0;
  assign res.res_data  = valid_q ? res_buf[rd_ptr][WIDTH-1:0] : '0;
  assign res.res_cout  = valid_q ? res_buf[rd_ptr][WIDTH] : 1'b0;
  assign res.res_last  = valid_q && (rd_ptr == LAST);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (SETTLE 0 and 2) on a
// behavioural ALU, checked each cycle against a timeline model.
module tb_alu_op_sequencer;

  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic       cmd_cin = 1'b0;
  logic       res_ready = 1'b1;

  logic [7:0] a_q [2];
  logic [7:0] b_q [2];
  logic       cin_q [2];
  logic [2:0] s_q [2];
  logic [7:0] out_w [2];
  logic       cout_w [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic       v_w [2];
  logic [2:0] op_w [2];
  logic [7:0] dat_w [2];
  logic       rc_w [2];
  logic       last_w [2];

  int tests = 0;
  int fails = 0;

  function automatic logic [8:0] alu_fn(logic [2:0] s, logic [7:0] a,
                                        logic [7:0] b, logic c);
    case (s)
      3'd0: return {1'b0, a} + {1'b0, b} + 9'(c);
      3'd1: return {1'b0, a} - {1'b0, b} - 9'(c);
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, ~a};
      3'd6: return {a, c};
      default: return {a[0], c, a[7:1]};
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_op_sequencer_if #(.WIDTH(8), .SEL_W(3)) rif ();
    alu_op_sequencer #(
      .WIDTH(8), .SEL_W(3), .NUM_OPS(N), .SETTLE(g * 2)
    ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
      .busy(busy_w[g]),
      .alu_a(a_q[g]), .alu_b(b_q[g]), .alu_cin(cin_q[g]), .alu_s(s_q[g]),
      .alu_out(out_w[g]), .alu_cout(cout_w[g]),
      .done(done_w[g]),
      .res(rif.master)
    );
    assign {cout_w[g], out_w[g]} = alu_fn(s_q[g], a_q[g], b_q[g], cin_q[g]);
    assign rif.res_ready = res_ready;
    assign v_w[g]    = rif.res_valid;
    assign op_w[g]   = rif.res_op;
    assign dat_w[g]  = rif.res_data;
    assign rc_w[g]   = rif.res_cout;
    assign last_w[g] = rif.res_last;
  end

  // Timeline model: k = edges since the accepting start edge.
  int         sett [2] = '{0, 2};
  bit         act [2];
  int         k [2];
  int         sent [2];
  logic [7:0] ma [2];
  logic [7:0] mb [2];
  logic       mc [2];
  logic [2:0] ms [2];
  bit         done_exp [2];
  bit         mrst [2];
  bit         lat_run [2];
  int         lat_cnt [2];
  int         lat [2];
  logic [11:0] cap0 [$];
  logic [11:0] cap1 [$];

  task automatic chk(string nm, int i, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t", nm, i, got, exp, $time);
    end
  endtask

  task automatic model_step(int i);
    int len;
    len = N * (sett[i] + 1);
    if (v_w[i] && res_ready) begin
      if (i == 0) cap0.push_back({op_w[i], rc_w[i], dat_w[i]});
      else        cap1.push_back({op_w[i], rc_w[i], dat_w[i]});
    end
    done_exp[i] = 1'b0;
    mrst[i] = 1'b0;
    if (lat_run[i]) lat_cnt[i]++;
    if (!rst_n) begin
      act[i] = 1'b0;
      ma[i] = '0; mb[i] = '0; mc[i] = 1'b0; ms[i] = '0;
      mrst[i] = 1'b1;
      lat_run[i] = 1'b0;
    end else if (!act[i]) begin
      if (start) begin
        act[i] = 1'b1; k[i] = 0; sent[i] = 0;
        ma[i] = cmd_a; mb[i] = cmd_b; mc[i] = cmd_cin;
        lat_run[i] = 1'b1; lat_cnt[i] = 0;
      end
    end else if (k[i] < len) begin
      k[i]++;
    end else if (res_ready) begin
      sent[i]++;
      if (sent[i] == N) begin
        act[i] = 1'b0; done_exp[i] = 1'b1; ms[i] = 3'(N - 1);
      end
    end
  endtask

  task automatic compare(int i);
    int len;
    bit ev;
    logic [8:0] r;
    len = N * (sett[i] + 1);
    ev = act[i] && (k[i] == len);
    if (lat_run[i] && v_w[i]) begin
      lat[i] = lat_cnt[i];
      lat_run[i] = 1'b0;
    end
    chk("busy", i, 32'(busy_w[i]), 32'(act[i]));
    chk("res_valid", i, 32'(v_w[i]), 32'(ev));
    chk("done", i, 32'(done_w[i]), 32'(done_exp[i]));
    chk("alu_a", i, 32'(a_q[i]), 32'(ma[i]));
    chk("alu_b", i, 32'(b_q[i]), 32'(mb[i]));
    chk("alu_cin", i, 32'(cin_q[i]), 32'(mc[i]));
    if (act[i])
      chk("alu_s", i, 32'(s_q[i]),
          (k[i] < len) ? 32'(k[i] / (sett[i] + 1)) : 32'(N - 1));
    else
      chk("alu_s", i, 32'(s_q[i]), 32'(ms[i]));
    if (ev) begin
      r = alu_fn(3'(sent[i]), ma[i], mb[i], mc[i]);
      chk("res_op", i, 32'(op_w[i]), 32'(sent[i]));
      chk("res_data", i, 32'(dat_w[i]), 32'(r[7:0]));
      chk("res_cout", i, 32'(rc_w[i]), 32'(r[8]));
      chk("res_last", i, 32'(last_w[i]), 32'(sent[i] == N - 1));
    end
    if (mrst[i]) begin
      chk("rst_res", i, {op_w[i], dat_w[i], rc_w[i], last_w[i]}, 32'd0);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
    for (int i = 0; i < 2; i++) compare(i);
  end

  // Ready driver: 0 always, 1 random, 2 stall on beat 3 then toggle.
  int rdy_mode = 0;
  int stall_n = 0;
  always @(negedge clk) begin
    case (rdy_mode)
      0: res_ready = 1'b1;
      1: res_ready = 1'($urandom_range(0, 1));
      default: begin
        if (act[0] && sent[0] == 3 && k[0] == N && stall_n < 5) begin
          res_ready = 1'b0;
          stall_n++;
        end else if (stall_n >= 5) begin
          res_ready = ~res_ready;
        end else begin
          res_ready = 1'b1;
        end
      end
    endcase
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic go(logic [7:0] a, logic [7:0] b, logic c);
    cmd_a = a; cmd_b = b; cmd_cin = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while ((busy_w[0] || busy_w[1]) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 0, 32'(busy_w[0] || busy_w[1]), 32'd0);
    tick();
  endtask

  logic [11:0] exp0 [8];
  logic [11:0] exp1 [8];
  int n;

  initial begin
    exp0 = '{12'h006, 12'h202, 12'h400, 12'h606,
             12'h806, 12'hAFB, 12'hC08, 12'hE02};
    exp1 = '{12'h101, 12'h2FD, 12'h401, 12'h6FF,
             12'h8FE, 12'hA00, 12'hDFF, 12'hFFF};

    // Reset with start held high, then release with start low.
    rst_n = 1'b0; start = 1'b1;
    tick(); tick();
    rst_n = 1'b1; start = 1'b0;
    tick(); tick(); tick();
    chk("post_rst_busy", 0, 32'(busy_w[0]), 32'd0);

    // Basic sweep 04/02/0 with ready held high.
    cap0.delete(); cap1.delete();
    go(8'h04, 8'h02, 1'b0);
    wait_idle(200);
    chk("lat0", 0, 32'(lat[0]), 32'd8);
    chk("beats0", 0, 32'(cap0.size()), 32'd8);
    for (int j = 0; j < 8; j++)
      if (j < cap0.size()) chk("pin0", j, 32'(cap0[j]), 32'(exp0[j]));

    // SETTLE=2 instance with FF/01/1.
    cap0.delete(); cap1.delete();
    go(8'hFF, 8'h01, 1'b1);
    wait_idle(200);
    chk("lat1", 1, 32'(lat[1]), 32'd24);
    chk("beats1", 1, 32'(cap1.size()), 32'd8);
    for (int j = 0; j < 8; j++)
      if (j < cap1.size()) chk("pin1", j, 32'(cap1[j]), 32'(exp1[j]));

    // Stall on beat 3, then toggling ready.
    cap0.delete();
    stall_n = 0;
    rdy_mode = 2;
    go(8'h04, 8'h02, 1'b0);
    wait_idle(300);
    chk("stall_seen", 0, 32'(stall_n >= 5), 32'd1);
    chk("beats_stall", 0, 32'(cap0.size()), 32'd8);
    for (int j = 0; j < 8; j++)
      if (j < cap0.size()) chk("order", j, 32'(cap0[j][11:9]), 32'(j));
    rdy_mode = 0;

    // Noise on start/cmd during a sweep; restart in the done cycle.
    go(8'h5A, 8'h33, 1'b1);
    n = 0;
    while (n < 200) begin
      if (done_w[0]) begin
        start = 1'b1;
        cmd_a = 8'h11;
        break;
      end
      start = 1'($urandom_range(0, 1));
      cmd_a = 8'($urandom);
      tick();
      n++;
    end
    chk("done_timeout", 0, 32'(n < 200), 32'd1);
    tick();
    start = 1'b0;
    chk("restart_busy", 0, 32'(busy_w[0]), 32'd1);
    chk("restart_a", 0, 32'(a_q[0]), 32'h11);
    wait_idle(300);

    // Reset in the middle of STREAM, then a fresh full sweep.
    go(8'h80, 8'h7F, 1'b0);
    n = 0;
    while (!(act[0] && sent[0] == 3) && n < 100) begin
      tick();
      n++;
    end
    chk("mid_timeout", 0, 32'(n < 100), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", 0, 32'(v_w[0]), 32'd0);
    chk("mid_rst_done", 0, 32'(done_w[0]), 32'd0);
    tick();
    cap0.delete();
    go(8'hC3, 8'h3C, 1'b1);
    wait_idle(200);
    chk("fresh_beats", 0, 32'(cap0.size()), 32'd8);

    // Random operands with random back-pressure.
    rdy_mode = 1;
    for (int t = 0; t < 8; t++) begin
      cap0.delete();
      go(8'($urandom), 8'($urandom), 1'($urandom));
      wait_idle(400);
      chk("rand_beats", t, 32'(cap0.size()), 32'd8);
    end
    rdy_mode = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
